// File: rtl/branch_update_queue_if.sv
// rtl/branch_update_queue_if.sv - handshake bundle between dispatch, branch unit, predictor and queue
//
// Parameters: TAG_W (tag width), IDX_W (predictor index width).
// master: dispatch / execution side (drives alloc_* and res_*, observes the rest).
// slave : the queue (observes alloc_* and res_*, drives ready, tag, update, mispredict, count).
//   alloc_valid/alloc_idx/alloc_pred -> alloc_ready/alloc_tag   allocation handshake
//   res_valid/res_tag/res_taken                                 out-of-order resolution
//   upd_valid/upd_idx/upd_taken                                 predictor write port
//   mispredict/mispredict_tag                                   squash notification
//   count                                                       occupied entries
interface branch_update_queue_if #(
  parameter int TAG_W = 3,
  parameter int IDX_W = 6
);
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_pred;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;
  logic [TAG_W:0]   count;

  modport master (
    output alloc_valid, alloc_idx, alloc_pred, res_valid, res_tag, res_taken,
    input  alloc_ready, alloc_tag, upd_valid, upd_idx, upd_taken,
           mispredict, mispredict_tag, count
  );

  modport slave (
    input  alloc_valid, alloc_idx, alloc_pred, res_valid, res_tag, res_taken,
    output alloc_ready, alloc_tag, upd_valid, upd_idx, upd_taken,
           mispredict, mispredict_tag, count
  );
endinterface

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order tracking queue for in-flight conditional branches
//
// Records predictor index and predicted direction at dispatch, accepts tagged
// out-of-order resolutions, flags mispredicts (squashing younger entries) and
// retires resolved branches in program order onto the predictor update port.
// Ports: clk, reset (synchronous, active-high), bq (branch_update_queue_if.slave).
// Optional macro BRQ_STATS_EN adds saturating 32-bit outputs stat_retired and
// stat_mispred (counts of upd_valid and mispredict pulses).
module branch_update_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int IDX_W = 6
) (
  input  logic clk,
  input  logic reset,
  branch_update_queue_if.slave bq
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0] stat_retired,
  output logic [31:0] stat_mispred
`endif
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]   head, tail;
  logic [TAG_W-1:0] head_slot, tail_slot;
  logic [TAG_W:0]   occupancy;
  logic             full;

  logic [DEPTH-1:0] ent_valid, ent_resolved, ent_pred, ent_taken;
  logic [IDX_W-1:0] ent_idx [DEPTH];
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] younger;

  logic [TAG_W-1:0] res_off;
  logic [TAG_W:0]   res_ptr;
  logic             res_in_range, res_live, res_mispred;
  logic             alloc_fire, pop;

  logic             upd_valid_q, upd_taken_q, mispredict_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic [TAG_W-1:0] mispredict_tag_q;

  assign head_slot = head[TAG_W-1:0];
  assign tail_slot = tail[TAG_W-1:0];
  assign occupancy = tail - head;
  assign full      = (head_slot == tail_slot) && (head[TAG_W] != tail[TAG_W]);

  // Age of the resolved tag relative to the head; in range means it is in flight.
  assign res_off      = bq.res_tag - head_slot;
  assign res_in_range = {1'b0, res_off} < occupancy;
  assign res_live     = bq.res_valid && ent_valid[bq.res_tag] &&
                        !ent_resolved[bq.res_tag] && res_in_range;
  assign res_mispred  = res_live && (bq.res_taken != ent_pred[bq.res_tag]);
  // Full pointer of the mispredicted entry, so the new tail keeps a correct wrap bit.
  assign res_ptr      = head + {1'b0, res_off};

  assign alloc_fire = bq.alloc_valid && bq.alloc_ready;
  // Retire looks only at registered state, so a same-cycle resolution of the head waits a cycle.
  assign pop        = ent_valid[head_slot] && ent_resolved[head_slot];

  always_comb begin
    younger = '0;
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = res_mispred &&
                   ((TAG_W'(i) - head_slot) > res_off) &&
                   ({1'b0, TAG_W'(i) - head_slot} < occupancy);
    end
  end

  always_comb begin
    valid_next = ent_valid & ~younger;
    if (pop)        valid_next[head_slot] = 1'b0;
    if (alloc_fire) valid_next[tail_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid        <= '0;
      ent_resolved     <= '0;
      head             <= '0;
      tail             <= '0;
      upd_valid_q      <= 1'b0;
      upd_idx_q        <= '0;
      upd_taken_q      <= 1'b0;
      mispredict_q     <= 1'b0;
      mispredict_tag_q <= '0;
    end else begin
      ent_valid <= valid_next;
      if (res_live) begin
        ent_resolved[bq.res_tag] <= 1'b1;
        ent_taken[bq.res_tag]    <= bq.res_taken;
      end
      if (alloc_fire) begin
        ent_resolved[tail_slot] <= 1'b0;
        ent_pred[tail_slot]     <= bq.alloc_pred;
        ent_idx[tail_slot]      <= bq.alloc_idx;
      end
      head <= head + {{TAG_W{1'b0}}, pop};
      if (res_mispred)     tail <= res_ptr + 1'b1;
      else if (alloc_fire) tail <= tail + 1'b1;
      upd_valid_q <= pop;
      if (pop) begin
        upd_idx_q   <= ent_idx[head_slot];
        upd_taken_q <= ent_taken[head_slot];
      end
      mispredict_q <= res_mispred;
      if (res_mispred) mispredict_tag_q <= bq.res_tag;
    end
  end

  assign bq.alloc_ready    = !full && !res_mispred;
  assign bq.alloc_tag      = tail_slot;
  assign bq.count          = occupancy;
  assign bq.upd_valid      = upd_valid_q;
  assign bq.upd_idx        = upd_idx_q;
  assign bq.upd_taken      = upd_taken_q;
  assign bq.mispredict     = mispredict_q;
  assign bq.mispredict_tag = mispredict_tag_q;

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_retired <= '0;
      stat_mispred <= '0;
    end else begin
      if (upd_valid_q && (stat_retired != 32'hFFFF_FFFF)) stat_retired <= stat_retired + 1'b1;
      if (mispredict_q && (stat_mispred != 32'hFFFF_FFFF)) stat_mispred <= stat_mispred + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - randomized self-checking bench for branch_update_queue
module tb_branch_update_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_update_queue_if #(.TAG_W(TAG_W), .IDX_W(IDX_W)) bif ();
`ifdef BRQ_STATS_EN
  logic [31:0] stat_retired, stat_mispred;
`endif

  branch_update_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bq    (bif)
`ifdef BRQ_STATS_EN
    ,
    .stat_retired (stat_retired),
    .stat_mispred (stat_mispred)
`endif
  );

  // Reference model: program-ordered list of in-flight branches with absolute sequence numbers.
  typedef struct {
    int seq;
    int idx;
    bit pred;
    bit resolved;
    bit taken;
  } ent_t;

  ent_t   q[$];
  int     next_seq;
  bit     exp_upd_valid, exp_upd_taken, exp_mis;
  int     exp_upd_idx, exp_mis_tag;
  longint exp_ret, exp_mp;
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_regs();
    check_eq("upd_valid", bif.upd_valid, exp_upd_valid);
    if (exp_upd_valid) begin
      check_eq("upd_idx", bif.upd_idx, exp_upd_idx);
      check_eq("upd_taken", bif.upd_taken, exp_upd_taken);
    end
    check_eq("mispredict", bif.mispredict, exp_mis);
    if (exp_mis) check_eq("mispredict_tag", bif.mispredict_tag, exp_mis_tag);
`ifdef BRQ_STATS_EN
    check_eq("stat_retired", stat_retired, exp_ret);
    check_eq("stat_mispred", stat_mispred, exp_mp);
`endif
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance model, check registered outputs.
  task automatic step(input bit av, input int aidx, input bit apred,
                      input bit rv, input int rtag, input bit rtaken);
    int hit;
    bit live, mis, pop, acc, exp_ready;
    bif.alloc_valid = av;
    bif.alloc_idx   = aidx[IDX_W-1:0];
    bif.alloc_pred  = apred;
    bif.res_valid   = rv;
    bif.res_tag     = rtag[TAG_W-1:0];
    bif.res_taken   = rtaken;
    hit = -1;
    if (rv) begin
      for (int k = 0; k < q.size(); k++)
        if ((q[k].seq % DEPTH) == rtag && !q[k].resolved) hit = k;
    end
    live = (hit >= 0);
    mis  = 1'b0;
    if (live) mis = (rtaken != q[hit].pred);
    pop       = (q.size() > 0) && q[0].resolved;
    exp_ready = (q.size() < DEPTH) && !mis;
    acc       = av && exp_ready;
    #1;
    check_eq("alloc_ready", bif.alloc_ready, exp_ready);
    check_eq("alloc_tag", bif.alloc_tag, next_seq % DEPTH);
    check_eq("count", bif.count, q.size());
    if (exp_upd_valid && exp_ret < 64'hFFFF_FFFF) exp_ret++;
    if (exp_mis && exp_mp < 64'hFFFF_FFFF) exp_mp++;
    exp_upd_valid = pop;
    if (pop) begin
      exp_upd_idx   = q[0].idx;
      exp_upd_taken = q[0].taken;
    end
    exp_mis = mis;
    if (mis) exp_mis_tag = rtag;
    if (live) begin
      q[hit].resolved = 1'b1;
      q[hit].taken    = rtaken;
    end
    if (mis) begin
      while (q.size() > hit + 1) void'(q.pop_back());
      next_seq = q[hit].seq + 1;
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{next_seq, aidx, apred, 1'b0, 1'b0});
      next_seq++;
    end
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.alloc_valid = 1'b1;
    bif.alloc_idx   = 6'd33;
    bif.alloc_pred  = 1'b1;
    bif.res_valid   = 1'b1;
    bif.res_tag     = '0;
    bif.res_taken   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bif.alloc_valid = 1'b0;
    bif.res_valid   = 1'b0;
    q.delete();
    next_seq      = 0;
    exp_upd_valid = 1'b0;
    exp_mis       = 1'b0;
    exp_ret       = 0;
    exp_mp        = 0;
    #1;
    check_eq("reset_count", bif.count, 0);
    check_eq("reset_alloc_ready", bif.alloc_ready, 1);
    check_regs();
  endtask

  initial begin
    int r, k;
    bit t;
    do_reset();

    // Three allocations, then two in-order-correct resolutions out of order.
    step(1, 5, 1, 0, 0, 0);
    step(1, 9, 0, 0, 0, 0);
    step(1, 12, 1, 0, 0, 0);
    check_eq("tp1_count", bif.count, 3);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);
    idle(3);

    // Fill to DEPTH, try a ninth allocation, then retire the head.
    for (int i = 0; i < DEPTH - 1; i++) step(1, 20 + i, 1, 0, 0, 0);
    check_eq("full_count", bif.count, DEPTH);
    step(1, 63, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 1);
    idle(3);

    // Mispredict on tag 2 with tags 0..4 in flight; later tag 4 resolution is stale.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 40 + i, 1, 0, 0, 0);
    step(1, 50, 0, 1, 2, 0);
    check_eq("tp4_mispredict", bif.mispredict, 1);
    check_eq("tp4_count", bif.count, 3);
    check_eq("tp4_alloc_tag", bif.alloc_tag, 3);
    step(0, 0, 0, 1, 4, 1);
    idle(2);

    // Randomized traffic, including wrap, stale/duplicate tags and squashes.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      k = -1;
      if (q.size() > 0 && r < 55) k = $urandom_range(0, q.size() - 1);
      if (k >= 0) begin
        t = ($urandom_range(0, 99) < 85) ? q[k].pred : !q[k].pred;
        step($urandom_range(0, 99) < 60, $urandom_range(0, 63), $urandom_range(0, 1),
             1, q[k].seq % DEPTH, t);
      end else begin
        step($urandom_range(0, 99) < 60, $urandom_range(0, 63), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 1));
      end
    end
    idle(4);

    // Reset with four entries in flight, two of them resolved but not at the head.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 10 + i, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 3, 0);
    do_reset();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
